// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter: round-robin owner of the regfile write port, with an  |
// | ack watchdog. Optional macro REGFILE_WB_ARB_X0_DROP_EN completes x0        |
// | writes locally without touching the regfile.            Revision: 1.0     |
// +--------------------------------------------------------------------------+
module regfile_wb_arbiter #(
   parameter int N_REQ       = 3,
   parameter int ACK_TIMEOUT = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req_valid,
   input  logic [N_REQ*5-1:0]  req_addr,
   input  logic [N_REQ*32-1:0] req_data,
   output logic [N_REQ-1:0]    req_ack,
   output logic                req_err,
   output logic [4:0]          wr_addr,
   output logic [31:0]         wr_data,
   output logic                wr_data_valid,
   input  logic                wr_ack,
   output logic                busy,
   output logic                timeout_err
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = $clog2(ACK_TIMEOUT);
   localparam logic [CW-1:0] C_CNT_LAST = CW'(ACK_TIMEOUT - 1);
   localparam logic [IW-1:0] C_PTR_RST  = IW'(N_REQ - 1);
`ifdef REGFILE_WB_ARB_X0_DROP_EN
   localparam bit C_X0_DROP = 1'b1;
`else
   localparam bit C_X0_DROP = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [4:0]        wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic              wr_valid_q, wr_valid_d;
   logic [N_REQ-1:0]  req_ack_q, req_ack_d;
   logic              req_err_q, req_err_d;
   logic              timeout_q, timeout_d;
   logic              busy_q, busy_d;

   logic              found;
   logic [IW-1:0]     pick;
   logic [4:0]        pick_addr;
   logic [31:0]       pick_data;

   function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
      int sum;
      sum = (int'(base) + k) % N_REQ;
      return IW'(sum);
   endfunction

   // Search starts just after the last served requester, so it ends up lowest priority.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!found && req_valid[rr_idx(rr_ptr_q, k)]) begin
            found = 1'b1;
            pick  = rr_idx(rr_ptr_q, k);
         end
      end
      pick_addr = req_addr[5*int'(pick) +: 5];
      pick_data = req_data[32*int'(pick) +: 32];
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      cnt_d      = cnt_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_valid_d = wr_valid_q;
      timeout_d  = timeout_q;
      req_ack_d  = '0;
      req_err_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = pick;
               cnt_d   = '0;
               if (C_X0_DROP && pick_addr == 5'd0) begin
                  req_ack_d = N_REQ'(1) << pick;
                  rr_ptr_d  = pick;
                  state_d   = ACK;
               end else begin
                  wr_addr_d  = pick_addr;
                  wr_data_d  = pick_data;
                  wr_valid_d = 1'b1;
                  state_d    = WRITE;
               end
            end
         end
         WRITE: begin
            // A late ack on the final watchdog cycle still counts as success.
            if (wr_ack || cnt_q == C_CNT_LAST) begin
               wr_valid_d = 1'b0;
               req_ack_d  = N_REQ'(1) << grant_q;
               rr_ptr_d   = grant_q;
               state_d    = ACK;
               if (!wr_ack) begin
                  req_err_d = 1'b1;
                  timeout_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d    = IDLE;
            wr_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= C_PTR_RST;
         grant_q    <= '0;
         cnt_q      <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_valid_q <= 1'b0;
         req_ack_q  <= '0;
         req_err_q  <= 1'b0;
         timeout_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         cnt_q      <= cnt_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_valid_q <= wr_valid_d;
         req_ack_q  <= req_ack_d;
         req_err_q  <= req_err_d;
         timeout_q  <= timeout_d;
         busy_q     <= busy_d;
      end
   end

   assign req_ack       = req_ack_q;
   assign req_err       = req_err_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign wr_data_valid = wr_valid_q;
   assign busy          = busy_q;
   assign timeout_err   = timeout_q;

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (wr_addr/wr_data/wr_data_valid/wr_ack) among N_REQ writeback requesters, e.g. ALU, load unit and CSR unit.
- Round-robin arbitration; one write is in flight at a time.
- A watchdog aborts a write the register file never acknowledges.
- Sits between the execute/writeback stages and regfile.

Parameters:
N_REQ, 3, number of writeback requesters (2..8)
ACK_TIMEOUT, 8, max cycles wr_data_valid may stay high without wr_ack before abort (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester write request; held high until req_ack
req_addr  in  N_REQ*5  requester i destination register at [5i+4:5i]
req_data  in  N_REQ*32  requester i write data at [32i+31:32i]
req_ack  out  N_REQ  one-cycle completion pulse to the granted requester
req_err  out  1  qualifies req_ack: 1 = write aborted by timeout
wr_addr  out  5  to regfile write address
wr_data  out  32  to regfile write data
wr_data_valid  out  1  to regfile write request
wr_ack  in  1  from regfile, write accepted
busy  out  1  high whenever state != IDLE
timeout_err  out  1  sticky flag, set on any timeout, cleared only by reset

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=N_REQ-1, and all outputs 0 (req_ack, req_err, wr_addr, wr_data, wr_data_valid, busy, timeout_err). Reset mid-transaction drops the write; the requester re-issues after reset.
- All outputs are registered.
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - If any req_valid is high, grant the first set bit searching from (rr_ptr+1) mod N_REQ upward with wrap.
  - Latch that requester's addr/data into wr_addr/wr_data, set wr_data_valid=1, clear the watchdog counter, go to WRITE.
  - Otherwise stay in IDLE.
- WRITE:
  - Hold wr_addr/wr_data/wr_data_valid stable.
  - If wr_ack=1 at the edge: wr_data_valid=0, req_ack[grant]=1, req_err=0, rr_ptr=grant, go to ACK.
  - Else if counter == ACK_TIMEOUT-1: wr_data_valid=0, req_ack[grant]=1, req_err=1, timeout_err=1, rr_ptr=grant, go to ACK.
  - Else counter+1.
  - wr_ack has priority over timeout when both occur at the same edge.
- ACK:
  - req_ack/req_err are high for exactly this cycle.
  - All req_valid are ignored this cycle; the granted requester drops or changes its request at the edge ending ACK.
  - Next cycle: req_ack=0, req_err=0, go to IDLE.
- Latency with a regfile that acks one cycle after valid:
  - req_valid rises in cycle 0 (IDLE).
  - wr_data_valid is high in cycles 1-2.
  - wr_ack is high in cycle 2.
  - req_ack is high in cycle 3.
  - Next grant is possible at the edge ending cycle 4.
  - Sustained throughput: one write per 4 cycles.
- wr_ack while in IDLE or ACK: ignored.
- req_valid changing while in WRITE: ignored; the latched addr/data are used.
- Fairness: after requester i is served, it is lowest priority. With all requesters active, service rotates 0,1,2,0,...

Optional Feature:
- Macro: REGFILE_WB_ARB_X0_DROP_EN.
- Defined: in IDLE, a granted request with addr==5'd0 does not assert wr_data_valid.
  - The FSM goes straight to ACK with req_ack[grant]=1, req_err=0, rr_ptr=grant.
  - Latency for that request: req_ack is high in cycle 1.
- Undefined: x0 writes go to the regfile like any other address.

Test Plan:
- Reset held 3 cycles -> all outputs 0, busy=0. Release, then req_valid=3'b001, addr0=5, data0=32'h10, regfile acks 1 cycle after valid -> wr_addr=5, wr_data=32'h10, wr_data_valid high 2 cycles, req_ack=3'b001 for 1 cycle with req_err=0; read port a at addr 5 returns 32'h10.
- req_valid=3'b111 held continuously (each requester re-asserts after its ack), addrs 1/2/3 -> writes issued in order 1,2,3,1; each req_ack is a single pulse; 4-cycle spacing between wr_data_valid rising edges.
- wr_ack tied 0, req_valid=3'b010 -> wr_data_valid high exactly 8 cycles, then req_ack=3'b010 with req_err=1, timeout_err=1 and stays 1 through later successful writes.
- reset asserted in WRITE state -> wr_data_valid and busy go 0 immediately, no req_ack pulse.
- With REGFILE_WB_ARB_X0_DROP_EN: req_valid=3'b100, addr2=0 -> wr_data_valid stays 0, req_ack=3'b100 in cycle 1. Without the macro: a normal write to addr 0 with wr_data_valid asserted.
